// File: rtl/mouse_pkg.sv
// Shared types and constants for the PS/2 mouse packet assembler.
// Holds the FSM state enum, the click codes and the delta clamp helper.
package mouse_pkg;

  typedef enum logic [1:0] {
    ST_B0 = 2'd0,
    ST_B1 = 2'd1,
    ST_B2 = 2'd2
  } mouse_state_e;

  localparam logic [7:0] BTN_NONE  = 8'd0;
  localparam logic [7:0] BTN_LEFT  = 8'd1;
  localparam logic [7:0] BTN_RIGHT = 8'd2;
  localparam logic [7:0] BTN_LONG  = 8'd3;

  localparam logic [7:0] CLAMP_POS = 8'h7F;
  localparam logic [7:0] CLAMP_NEG = 8'h81;

  // Symmetric clamp to +/-127 so -128 never leaves the block and Y negation is safe.
  function automatic logic [7:0] clamp_delta(input logic ovf, input logic [8:0] raw);
    logic [7:0] res;
    if (ovf)
      res = raw[8] ? CLAMP_NEG : CLAMP_POS;
    else if ($signed(raw) > 9'sd127)
      res = CLAMP_POS;
    else if ($signed(raw) < -9'sd127)
      res = CLAMP_NEG;
    else
      res = raw[7:0];
    return res;
  endfunction

endpackage

// File: rtl/mouse_packet_if.sv
// Byte-in / packet-out bus of mouse_packet, plus FSM state for observation.
// All strobes are single-cycle with no backpressure: rx_valid qualifies rx_data for
// exactly one cycle, valid_o qualifies data_x/data_y/btn_o updates, sync_err is an event.
interface mouse_packet_if;
  import mouse_pkg::*;

  logic [7:0]   rx_data;
  logic         rx_valid;
  logic [7:0]   data_x;
  logic [7:0]   data_y;
  logic [7:0]   btn_o;
  logic         valid_o;
  logic         sync_err;
  mouse_state_e state;

  modport slave (
    input  rx_data, rx_valid,
    output data_x, data_y, btn_o, valid_o, sync_err, state
  );

  modport master (
    output rx_data, rx_valid,
    input  data_x, data_y, btn_o, valid_o, sync_err, state
  );
endinterface

// File: rtl/mouse_click_classifier.sv
// Turns per-packet L/R button levels into none/left/right/long click codes.
// code is combinational and only meaningful in the cycle pkt is high.
module mouse_click_classifier
  import mouse_pkg::*;
#(
  parameter int LONG_CYCLES = 50_000_000,
  parameter int CNT_W       = 27
) (
  input  logic       clk,
  input  logic       rst_p,
  input  logic       pkt,
  input  logic       l,
  input  logic       r,
  output logic [7:0] code
);

  localparam logic [CNT_W-1:0] LONG_MAX = CNT_W'(LONG_CYCLES);

  logic [CNT_W-1:0] hold_cnt;
  logic             l_hist;
  logic             r_hist;
  logic             long_done;
  logic             press;
  logic             long_evt;
  logic             left_evt;
  logic             right_evt;

  always_comb begin
    press     = l && !l_hist;
    long_evt  = l && l_hist && !long_done && (hold_cnt >= LONG_MAX);
    left_evt  = !l && l_hist && !long_done;
    right_evt = !r && r_hist;
    code      = BTN_NONE;
    if (long_evt)
      code = BTN_LONG;
    else if (left_evt)
      code = BTN_LEFT;
    else if (right_evt)
      code = BTN_RIGHT;
  end

  always_ff @(posedge clk or posedge rst_p) begin
    if (rst_p) begin
      hold_cnt  <= '0;
      l_hist    <= 1'b0;
      r_hist    <= 1'b0;
      long_done <= 1'b0;
    end else begin
      // Hold time runs off the packet-level L history, so it counts between packets.
      if (pkt && press)
        hold_cnt <= '0;
      else if (l_hist && (hold_cnt < LONG_MAX))
        hold_cnt <= hold_cnt + CNT_W'(1);

      if (pkt) begin
        l_hist <= l;
        r_hist <= r;
        if (press)
          long_done <= 1'b0;
        else if (long_evt)
          long_done <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/mouse_packet.sv
// Assembles 3-byte PS/2 mouse packets into clamped X/Y deltas and a click code.
// Define MOUSE_Y_INVERT_EN to negate data_y into screen (downward-positive) coordinates.
module mouse_packet
  import mouse_pkg::*;
#(
  parameter int LONG_CYCLES    = 50_000_000,
  parameter int TIMEOUT_CYCLES = 100_000,
  parameter int CNT_W          = 27
) (
  input  logic           clk,
  input  logic           rst_p,
  mouse_packet_if.slave  bus
);

  localparam logic [CNT_W-1:0] TMO_MAX = CNT_W'(TIMEOUT_CYCLES);

  mouse_state_e     state;
  mouse_state_e     state_n;
  logic [CNT_W-1:0] tmo_cnt;
  logic [3:0]       hdr_q;     // b0[7:4]: Y ovf, X ovf, Y sign, X sign
  logic [1:0]       btn_q;     // b0[1:0]: R, L
  logic [7:0]       b1_q;

  logic       timeout;
  logic       accept_b0;
  logic       accept_b1;
  logic       accept_b2;
  logic       err_n;
  logic [8:0] dx;
  logic [8:0] dy;
  logic [7:0] cx;
  logic [7:0] cy;
  logic [7:0] y_out;
  logic [7:0] btn_code;

  assign bus.state = state;

  always_comb begin
    state_n   = state;
    timeout   = (state != ST_B0) && (tmo_cnt == TMO_MAX);
    accept_b0 = 1'b0;
    accept_b1 = 1'b0;
    accept_b2 = 1'b0;
    err_n     = timeout;
    // On timeout the same-cycle byte is judged as a fresh B0 candidate.
    if (timeout || state == ST_B0) begin
      state_n = ST_B0;
      if (bus.rx_valid) begin
        if (bus.rx_data[3]) begin
          accept_b0 = 1'b1;
          state_n   = ST_B1;
        end else begin
          err_n = 1'b1;
        end
      end
    end else if (state == ST_B1) begin
      if (bus.rx_valid) begin
        accept_b1 = 1'b1;
        state_n   = ST_B2;
      end
    end else begin
      if (bus.rx_valid) begin
        accept_b2 = 1'b1;
        state_n   = ST_B0;
      end
    end
  end

  always_comb begin
    dx = {hdr_q[0], b1_q};
    dy = {hdr_q[1], bus.rx_data};
    cx = clamp_delta(hdr_q[2], dx);
    cy = clamp_delta(hdr_q[3], dy);
`ifdef MOUSE_Y_INVERT_EN
    y_out = ~cy + 8'd1;
`else
    y_out = cy;
`endif
  end

  mouse_click_classifier #(
    .LONG_CYCLES (LONG_CYCLES),
    .CNT_W       (CNT_W)
  ) u_click (
    .clk   (clk),
    .rst_p (rst_p),
    .pkt   (accept_b2),
    .l     (btn_q[0]),
    .r     (btn_q[1]),
    .code  (btn_code)
  );

  always_ff @(posedge clk or posedge rst_p) begin
    if (rst_p) begin
      state        <= ST_B0;
      tmo_cnt      <= '0;
      hdr_q        <= '0;
      btn_q        <= '0;
      b1_q         <= '0;
      bus.data_x   <= '0;
      bus.data_y   <= '0;
      bus.btn_o    <= '0;
      bus.valid_o  <= 1'b0;
      bus.sync_err <= 1'b0;
    end else begin
      state        <= state_n;
      bus.valid_o  <= accept_b2;
      bus.sync_err <= err_n;

      if (accept_b0 || accept_b1 || accept_b2 || state_n == ST_B0)
        tmo_cnt <= '0;
      else
        tmo_cnt <= tmo_cnt + CNT_W'(1);

      if (accept_b0) begin
        hdr_q <= bus.rx_data[7:4];
        btn_q <= bus.rx_data[1:0];
      end
      if (accept_b1)
        b1_q <= bus.rx_data;
      if (accept_b2) begin
        bus.data_x <= cx;
        bus.data_y <= y_out;
        bus.btn_o  <= btn_code;
      end
    end
  end

endmodule

// File: tb/tb_mouse_packet.sv
// Directed bench for mouse_packet: byte driver, expected-packet queue checked on valid_o.
module tb_mouse_packet;
  import mouse_pkg::*;

  localparam int LONG_CYCLES    = 100;
  localparam int TIMEOUT_CYCLES = 20;
  localparam int CNT_W          = 16;

  logic clk;
  logic rst_p;
  mouse_packet_if dif();

  mouse_packet #(
    .LONG_CYCLES    (LONG_CYCLES),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .CNT_W          (CNT_W)
  ) dut (
    .clk   (clk),
    .rst_p (rst_p),
    .bus   (dif)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int serr_cnt = 0;
  int s0;
  logic [23:0] exp_q[$];

  task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] y_exp(input logic [7:0] y_native);
`ifdef MOUSE_Y_INVERT_EN
    return ~y_native + 8'd1;
`else
    return y_native;
`endif
  endfunction

  // scoreboard
  always @(negedge clk) begin
    if (!rst_p) begin
      if (dif.sync_err) serr_cnt++;
      if (dif.valid_o) begin
        logic [23:0] e;
        tests++;
        assert (exp_q.size() > 0) else begin
          fails++;
          $error("FAIL spurious_valid observed=1 expected=0 (queue empty)");
        end
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check8("data_x", dif.data_x, e[23:16]);
          check8("data_y", dif.data_y, e[15:8]);
          check8("btn_o",  dif.btn_o,  e[7:0]);
        end
      end
    end
  end

  // drivers
  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    dif.rx_data  = b;
    dif.rx_valid = 1'b1;
    @(negedge clk);
    dif.rx_valid = 1'b0;
  endtask

  task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                          input logic [7:0] ex, input logic [7:0] ey, input logic [7:0] eb);
    send_byte(b0);
    send_byte(b1);
    exp_q.push_back({ex, y_exp(ey), eb});
    send_byte(b2);
    check8("valid_latency", {7'd0, dif.valid_o}, 8'd1);
  endtask

  initial begin
    dif.rx_data  = 8'h00;
    dif.rx_valid = 1'b0;
    rst_p = 1'b1;
    wait_cycles(3);
    rst_p = 1'b0;
    wait_cycles(1);

    check8("rst_data_x", dif.data_x, 8'h00);
    check8("rst_data_y", dif.data_y, 8'h00);
    check8("rst_btn_o", dif.btn_o, 8'h00);
    check8("rst_valid", {7'd0, dif.valid_o}, 8'd0);
    check8("rst_sync_err", {7'd0, dif.sync_err}, 8'd0);
    check8("rst_state", 8'(dif.state), 8'(ST_B0));

    // basic decode and clamp boundaries
    s0 = serr_cnt;
    send_pkt(8'h08, 8'h05, 8'h03, 8'h05, 8'h03, BTN_NONE);
    send_pkt(8'h18, 8'h10, 8'h00, 8'h81, 8'h00, BTN_NONE);
    send_pkt(8'h48, 8'h00, 8'h00, 8'h7F, 8'h00, BTN_NONE);
    send_pkt(8'h18, 8'h81, 8'h00, 8'h81, 8'h00, BTN_NONE);
    send_pkt(8'h18, 8'h80, 8'h00, 8'h81, 8'h00, BTN_NONE);
    send_pkt(8'h08, 8'h7F, 8'h80, 8'h7F, 8'h7F, BTN_NONE);
    send_pkt(8'hA8, 8'h80, 8'h00, 8'h7F, 8'h81, BTN_NONE);
    send_pkt(8'h38, 8'hFF, 8'hF0, 8'hFF, 8'hF0, BTN_NONE);
    wait_cycles(2);
    check8("no_serr_clean", 8'(serr_cnt - s0), 8'd0);

    // misaligned first byte is dropped
    s0 = serr_cnt;
    send_byte(8'h05);
    wait_cycles(3);
    check8("serr_drop", 8'(serr_cnt - s0), 8'd1);
    send_pkt(8'h08, 8'h01, 8'h01, 8'h01, 8'h01, BTN_NONE);

    // inter-byte timeout
    s0 = serr_cnt;
    send_byte(8'h08);
    send_byte(8'h01);
    wait_cycles(TIMEOUT_CYCLES + 10);
    check8("serr_timeout", 8'(serr_cnt - s0), 8'd1);
    check8("state_after_timeout", 8'(dif.state), 8'(ST_B0));
    send_pkt(8'h08, 8'h02, 8'h00, 8'h02, 8'h00, BTN_NONE);

    // short left click
    send_pkt(8'h09, 8'h00, 8'h00, 8'h00, 8'h00, BTN_NONE);
    wait_cycles(20);
    send_pkt(8'h08, 8'h00, 8'h00, 8'h00, 8'h00, BTN_LEFT);
    wait_cycles(10);

    // long click: packet starts every 40 cycles, hold passes 100 at the fourth packet
    for (int i = 0; i < 5; i++) begin
      send_pkt(8'h09, 8'h00, 8'h00, 8'h00, 8'h00, (i == 3) ? BTN_LONG : BTN_NONE);
      wait_cycles(34);
    end
    send_pkt(8'h08, 8'h00, 8'h00, 8'h00, 8'h00, BTN_NONE);

    // right click
    send_pkt(8'h0A, 8'h03, 8'h00, 8'h03, 8'h00, BTN_NONE);
    send_pkt(8'h08, 8'h04, 8'h00, 8'h04, 8'h00, BTN_RIGHT);
    wait_cycles(3);

    // reset mid-packet
    send_byte(8'h08);
    send_byte(8'h05);
    rst_p = 1'b1;
    wait_cycles(2);
    check8("midrst_data_x", dif.data_x, 8'h00);
    check8("midrst_data_y", dif.data_y, 8'h00);
    check8("midrst_btn_o", dif.btn_o, 8'h00);
    check8("midrst_valid", {7'd0, dif.valid_o}, 8'd0);
    check8("midrst_state", 8'(dif.state), 8'(ST_B0));
    rst_p = 1'b0;
    wait_cycles(2);
    s0 = serr_cnt;
    send_pkt(8'h08, 8'h05, 8'h03, 8'h05, 8'h03, BTN_NONE);
    wait_cycles(5);
    check8("no_serr_after_rst", 8'(serr_cnt - s0), 8'd0);
    check8("queue_drained", 8'(exp_q.size()), 8'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
